alu_system_control_unit: RTL and testbench

//  Hardwired micro-sequencer driving every control input of ALUSystem (RF, ARF, IR, Memory, MuxA/B/C, ALU).

---
 rtl/alu_system_control_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_alu_system_control_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_system_control_unit.sv
// Hardwired fetch/decode/execute sequencer for ALUSystem; each micro-step holds its controls for STEP_CYCLES clocks.
// Optional build macro CU_SINGLE_STEP_EN adds a Step input that gates each instruction at the start of FETCH_L.
module alu_system_control_unit #(
  parameter int STEP_CYCLES = 4
) (
  input  logic        Clock,
  input  logic        Reset_n,
`ifdef CU_SINGLE_STEP_EN
  input  logic        Step,
`endif
  input  logic [15:0] IR_In,
  input  logic [3:0]  Flags_In,
  output logic [2:0]  RF_O1Sel,
  output logic [2:0]  RF_O2Sel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RSel,
  output logic [3:0]  RF_TSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutASel,
  output logic [1:0]  ARF_OutBSel,
  output logic [1:0]  ARF_FunSel,
  output logic [3:0]  ARF_RSel,
  output logic        IR_LH,
  output logic        IR_Enable,
  output logic [1:0]  IR_Funsel,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic        Halted,
  output logic [2:0]  State
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(STEP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_FETCH_L = 3'd1,
    S_FETCH_H = 3'd2,
    S_DECODE  = 3'd3,
    S_EXEC1   = 3'd4,
    S_EXEC2   = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] step_cnt_q, step_cnt_d;
  logic [15:0]   ir_q, ir_d;
  logic          z_q, z_d;

  logic          last;
  logic          hold;
  logic [3:0]    op;
  logic [1:0]    rd;
  logic [1:0]    rs;
  logic [3:0]    rd_sel;
  logic [3:0]    alu_fun;
  logic          take_branch;
  logic          unused_flags;

  assign op           = ir_q[15:12];
  assign rd           = ir_q[11:10];
  assign rs           = ir_q[9:8];
  assign rd_sel       = 4'b1000 >> rd;
  assign last         = (step_cnt_q == LAST_CNT);
  assign take_branch  = (op == 4'hB) || (op == 4'hC && z_q) || (op == 4'hD && !z_q);
  assign unused_flags = ^Flags_In[3:1];

`ifdef CU_SINGLE_STEP_EN
  assign hold = (state_q == S_FETCH_L) && (step_cnt_q == '0) && !Step;
`else
  assign hold = 1'b0;
`endif

  assign Halted = (state_q == S_HALT);
  assign State  = state_q;

  always_comb begin
    case (op)
      4'h3:    alu_fun = 4'b0100;
      4'h4:    alu_fun = 4'b0101;
      4'h5:    alu_fun = 4'b0111;
      4'h6:    alu_fun = 4'b1000;
      4'h7:    alu_fun = 4'b1010;
      4'h8:    alu_fun = 4'b0010;
      default: alu_fun = 4'b0000;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_INIT;
      step_cnt_q <= '0;
      ir_q       <= '0;
      z_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      ir_q       <= ir_d;
      z_q        <= z_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_cnt_d  = (last || hold) ? '0 : step_cnt_q + 1'b1;
    ir_d        = ir_q;
    z_d         = z_q;
    RF_O1Sel    = 3'b000;
    RF_O2Sel    = 3'b000;
    RF_FunSel   = 2'b00;
    RF_RSel     = 4'b0000;
    RF_TSel     = 4'b0000;
    ALU_FunSel  = 4'b0000;
    ARF_OutASel = 2'b00;
    ARF_OutBSel = 2'b00;
    ARF_FunSel  = 2'b00;
    ARF_RSel    = 4'b0000;
    IR_LH       = 1'b0;
    IR_Enable   = 1'b0;
    IR_Funsel   = 2'b00;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 1'b0;

    case (state_q)
      S_INIT: begin
        if (last) begin
          RF_RSel  = 4'b1111;
          RF_TSel  = 4'b1111;
          ARF_RSel = 4'b1110;
          state_d  = S_FETCH_L;
        end
      end
      S_FETCH_L, S_FETCH_H: begin
        // PC drives the memory address for the whole step; PC+1 and the IR byte land together.
        if (!hold) begin
          ARF_OutBSel = 2'b11;
          Mem_CS      = 1'b0;
          IR_Funsel   = 2'b01;
          IR_LH       = (state_q == S_FETCH_H);
          if (last) begin
            IR_Enable  = 1'b1;
            ARF_FunSel = 2'b10;
            ARF_RSel   = 4'b1000;
            state_d    = (state_q == S_FETCH_L) ? S_FETCH_H : S_DECODE;
          end
        end
      end
      S_DECODE: begin
        step_cnt_d = '0;
        ir_d       = IR_In;
        case (IR_In[15:12])
          4'hF:    state_d = S_HALT;
          4'hE:    state_d = S_FETCH_L;
          default: state_d = S_EXEC1;
        endcase
      end
      S_EXEC1: begin
        case (op)
          4'h0: begin
            MuxASel   = 2'b10;
            RF_FunSel = 2'b01;
            if (last) RF_RSel = rd_sel;
          end
          4'h1, 4'h2: begin
            MuxBSel    = 2'b10;
            ARF_FunSel = 2'b01;
            if (last) ARF_RSel = 4'b0100;
          end
          4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
            RF_O1Sel   = (op == 4'h8) ? {1'b1, rs} : {1'b1, rd};
            RF_O2Sel   = {1'b1, rs};
            ALU_FunSel = alu_fun;
            if (last) begin
              RF_RSel = rd_sel;
              z_d     = Flags_In[0];
            end
            RF_FunSel = 2'b01;
          end
          4'h9, 4'hA: begin
            RF_FunSel = (op == 4'h9) ? 2'b11 : 2'b10;
            if (last) RF_RSel = rd_sel;
          end
          4'hB, 4'hC, 4'hD: begin
            if (take_branch) begin
              MuxBSel    = 2'b10;
              ARF_FunSel = 2'b01;
              if (last) ARF_RSel = 4'b1000;
            end
          end
          default: ;
        endcase
        if (last) state_d = (op == 4'h1 || op == 4'h2) ? S_EXEC2 : S_FETCH_L;
      end
      S_EXEC2: begin
        ARF_OutBSel = 2'b00;
        if (op == 4'h1) begin
          Mem_CS    = 1'b0;
          MuxASel   = 2'b01;
          RF_FunSel = 2'b01;
          if (last) RF_RSel = rd_sel;
        end else begin
          // Store: ALU passes Rs through to the memory data input; the write is a single-cycle strobe.
          RF_O1Sel   = {1'b1, rs};
          ALU_FunSel = 4'b0000;
          if (last) begin
            Mem_CS = 1'b0;
            Mem_WR = 1'b1;
          end
        end
        if (last) state_d = S_FETCH_L;
      end
      S_HALT: begin
        step_cnt_d = '0;
      end
      default: begin
        step_cnt_d = '0;
        state_d    = S_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_system_control_unit.sv
// Drives the control unit with a behavioural ALUSystem datapath and compares the architectural
// state it produces against an instruction-level model of the ISA.
module tb_alu_system_control_unit;

  localparam int SC = 4;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic [15:0] IR_In;
  logic [3:0]  Flags_In;
  logic [2:0]  RF_O1Sel, RF_O2Sel;
  logic [1:0]  RF_FunSel;
  logic [3:0]  RF_RSel, RF_TSel, ALU_FunSel;
  logic [1:0]  ARF_OutASel, ARF_OutBSel, ARF_FunSel;
  logic [3:0]  ARF_RSel;
  logic        IR_LH, IR_Enable;
  logic [1:0]  IR_Funsel;
  logic        Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel;
  logic        Halted;
  logic [2:0]  State;
`ifdef CU_SINGLE_STEP_EN
  logic        step_in = 1'b1;
`endif

  always #5 Clock = ~Clock;

  alu_system_control_unit #(.STEP_CYCLES(SC)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
`ifdef CU_SINGLE_STEP_EN
    .Step(step_in),
`endif
    .IR_In(IR_In), .Flags_In(Flags_In),
    .RF_O1Sel(RF_O1Sel), .RF_O2Sel(RF_O2Sel), .RF_FunSel(RF_FunSel),
    .RF_RSel(RF_RSel), .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel),
    .ARF_OutASel(ARF_OutASel), .ARF_OutBSel(ARF_OutBSel), .ARF_FunSel(ARF_FunSel),
    .ARF_RSel(ARF_RSel), .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
    .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
    .MuxCSel(MuxCSel), .Halted(Halted), .State(State)
  );

  // ---------------- behavioural ALUSystem datapath ----------------
  logic [7:0]  dp_r [4];
  logic [7:0]  dp_pc, dp_ar, dp_sp;
  logic [15:0] dp_ir;
  logic [7:0]  dp_mem [256];
  logic [7:0]  prog_mem [256];
  logic        load_req = 1'b0;

  logic [7:0] o1, o2, alu_a, alu_out, arf_outa, arf_outb, mem_out, mux_a, mux_b;
  logic       strobe;

  assign o1       = RF_O1Sel[2] ? dp_r[RF_O1Sel[1:0]] : 8'h00;
  assign o2       = RF_O2Sel[2] ? dp_r[RF_O2Sel[1:0]] : 8'h00;
  assign arf_outa = (ARF_OutASel == 2'b11) ? dp_pc : (ARF_OutASel == 2'b01) ? dp_sp : dp_ar;
  assign arf_outb = (ARF_OutBSel == 2'b11) ? dp_pc : (ARF_OutBSel == 2'b01) ? dp_sp : dp_ar;
  assign alu_a    = MuxCSel ? arf_outa : o1;
  assign mem_out  = dp_mem[arf_outb];

  always_comb begin
    case (ALU_FunSel)
      4'b0010: alu_out = ~alu_a;
      4'b0100: alu_out = alu_a + o2;
      4'b0101: alu_out = alu_a - o2;
      4'b0111: alu_out = alu_a & o2;
      4'b1000: alu_out = alu_a | o2;
      4'b1010: alu_out = alu_a ^ o2;
      default: alu_out = alu_a;
    endcase
  end

  assign mux_a    = (MuxASel == 2'b01) ? mem_out : (MuxASel == 2'b10) ? dp_ir[7:0] :
                    (MuxASel == 2'b11) ? arf_outa : alu_out;
  assign mux_b    = (MuxBSel == 2'b01) ? mem_out : (MuxBSel == 2'b10) ? dp_ir[7:0] : alu_out;
  assign IR_In    = dp_ir;
  assign Flags_In = {3'b000, alu_out == 8'h00};
  assign strobe   = (|RF_RSel) || (|RF_TSel) || (|ARF_RSel) || IR_Enable || (!Mem_CS && Mem_WR);

  function automatic logic [7:0] fun_apply(input logic [1:0] fs, input logic [7:0] cur, input logic [7:0] din);
    case (fs)
      2'b00:   return 8'h00;
      2'b01:   return din;
      2'b10:   return cur - 8'd1;
      default: return cur + 8'd1;
    endcase
  endfunction

  // ARF funsel is 10 = increment, 11 = decrement (differs from RF encoding)
  function automatic logic [7:0] arf_apply(input logic [1:0] fs, input logic [7:0] cur, input logic [7:0] din);
    case (fs)
      2'b00:   return 8'h00;
      2'b01:   return din;
      2'b10:   return cur + 8'd1;
      default: return cur - 8'd1;
    endcase
  endfunction

  always @(posedge Clock) begin
    if (load_req) begin
      for (int i = 0; i < 256; i++) dp_mem[i] <= prog_mem[i];
      for (int i = 0; i < 4; i++) dp_r[i] <= 8'h5A ^ 8'(i);
      dp_pc <= 8'hC3; dp_ar <= 8'h3C; dp_sp <= 8'h99; dp_ir <= 16'hE0E0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (RF_RSel[3-i]) dp_r[i] <= fun_apply(RF_FunSel, dp_r[i], mux_a);
      if (ARF_RSel[3]) dp_pc <= arf_apply(ARF_FunSel, dp_pc, mux_b);
      if (ARF_RSel[2]) dp_ar <= arf_apply(ARF_FunSel, dp_ar, mux_b);
      if (ARF_RSel[1]) dp_sp <= arf_apply(ARF_FunSel, dp_sp, mux_b);
      if (IR_Enable && IR_Funsel == 2'b01) begin
        if (IR_LH) dp_ir[15:8] <= mem_out;
        else       dp_ir[7:0]  <= mem_out;
      end
      if (!Mem_CS && Mem_WR) dp_mem[arf_outb] <= alu_out;
    end
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Step-shape monitor: a write strobe must be the final cycle of its state's residency,
  // and every timed state lasts exactly SC clocks (DECODE exactly one).
  logic       prev_strobe = 1'b0;
  logic [2:0] prev_state = 3'd0;
  logic [2:0] run_state = 3'd0;
  int         run_len = 0;
  logic       run_valid = 1'b0;

  always @(negedge Clock) begin
    if (!Reset_n) begin
      prev_strobe <= 1'b0;
      run_valid   <= 1'b0;
      run_len     <= 0;
      run_state   <= State;
      prev_state  <= State;
    end else begin
      if (prev_strobe) chk("strobe_not_last_cycle", 32'(State != prev_state), 32'd1);
      if (State == run_state) begin
        run_len <= run_len + 1;
      end else begin
        if (run_valid && run_state != 3'd6)
          chk($sformatf("step_len_state%0d", run_state), run_len, (run_state == 3'd3) ? 1 : SC);
        run_valid <= 1'b1;
        run_state <= State;
        run_len   <= 1;
      end
      prev_strobe <= strobe;
      prev_state  <= State;
    end
  end

  // ---------------- ISA-level reference model ----------------
  logic [7:0] m_r [4];
  logic [7:0] m_mem [256];
  logic [7:0] m_pc;
  logic       m_z;

  task automatic do_reset();
    Reset_n  = 1'b0;
    load_req = 1'b1;
    @(posedge Clock); #1;
    load_req = 1'b0;
    @(negedge Clock); #1;
    Reset_n = 1'b1;
  endtask

  task automatic fill_nops();
    for (int i = 0; i < 256; i++) prog_mem[i] = (i % 2 == 0) ? 8'h00 : 8'hE0;
  endtask

  task automatic put_word(input int addr, input logic [15:0] w);
    prog_mem[addr]     = w[7:0];
    prog_mem[addr + 1] = w[15:8];
  endtask

  task automatic wait_decode(output bit ok);
    ok = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge Clock);
      if (State == 3'd3) begin
        ok = 1;
        return;
      end
    end
  endtask

  task automatic model_exec(input logic [15:0] w);
    logic [3:0] op;
    logic [1:0] rd, rs;
    logic [7:0] imm, res;
    op = w[15:12]; rd = w[11:10]; rs = w[9:8]; imm = w[7:0];
    case (op)
      4'h0: m_r[rd] = imm;
      4'h1: m_r[rd] = m_mem[imm];
      4'h2: m_mem[imm] = m_r[rs];
      4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
        case (op)
          4'h3:    res = m_r[rd] + m_r[rs];
          4'h4:    res = m_r[rd] - m_r[rs];
          4'h5:    res = m_r[rd] & m_r[rs];
          4'h6:    res = m_r[rd] | m_r[rs];
          4'h7:    res = m_r[rd] ^ m_r[rs];
          default: res = ~m_r[rs];
        endcase
        m_r[rd] = res;
        m_z = (res == 8'h00);
      end
      4'h9: m_r[rd] = m_r[rd] + 8'd1;
      4'hA: m_r[rd] = m_r[rd] - 8'd1;
      4'hB: m_pc = imm;
      4'hC: if (m_z) m_pc = imm;
      4'hD: if (!m_z) m_pc = imm;
      default: ;
    endcase
  endtask

  task automatic run_program(input int max_instr);
    bit ok;
    logic [15:0] w;
    logic [7:0] pc1;
    int quiet;
    do_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    for (int i = 0; i < 256; i++) m_mem[i] = prog_mem[i];
    m_pc = 8'h00;
    m_z  = 1'b0;
    for (int k = 0; k <= max_instr; k++) begin
      wait_decode(ok);
      chk("decode_reached", 32'(ok), 32'd1);
      if (!ok) break;
      for (int i = 0; i < 4; i++) chk($sformatf("R%0d", i + 1), dp_r[i], m_r[i]);
      pc1  = m_pc + 8'd1;
      w    = {m_mem[pc1], m_mem[m_pc]};
      m_pc = m_pc + 8'd2;
      chk("pc_after_fetch", dp_pc, m_pc);
      chk("ir_fetched", dp_ir, w);
      if (k == max_instr) break;
      if (w[15:12] == 4'hF) begin
        @(negedge Clock);
        chk("halted", 32'(Halted), 32'd1);
        chk("halt_state", 32'(State), 32'd6);
        quiet = 0;
        for (int c = 0; c < 100; c++) begin
          @(negedge Clock);
          if (strobe || State != 3'd6) quiet++;
        end
        chk("halt_quiet_cycles", quiet, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("R%0d_at_halt", i + 1), dp_r[i], m_r[i]);
        break;
      end
      model_exec(w);
    end
    for (int i = 0; i < 256; i++) chk($sformatf("mem[%0h]", i), dp_mem[i], m_mem[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] w;
    fill_nops();

    // reset values
    Reset_n = 1'b0;
    #12;
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_halted", 32'(Halted), 32'd0);
    chk("rst_mem_cs", 32'(Mem_CS), 32'd1);
    chk("rst_strobes", 32'(strobe), 32'd0);

    // LDI R1,5 from reset: R1 lands on clock 17, PC=2
    put_word(0, 16'h0005);
    do_reset();
    repeat (16) @(posedge Clock);
    #1;
    chk("r1_before_clk17", dp_r[0], 8'h00);
    chk("state_exec1_clk16", 32'(State), 32'd4);
    @(posedge Clock); #1;
    chk("r1_at_clk17", dp_r[0], 8'h05);
    chk("pc_at_clk17", dp_pc, 8'h02);

    // reset in the middle of the LDI execute step: no write
    fill_nops();
    put_word(0, 16'h0077);
    do_reset();
    repeat (15) @(posedge Clock);
    #1;
    Reset_n = 1'b0;
    #1;
    chk("midstep_rst_state", 32'(State), 32'd0);
    repeat (2) @(posedge Clock);
    #1;
    chk("midstep_r1_unchanged", dp_r[0], 8'h00);

    // SUB to zero then BEQ taken
    fill_nops();
    put_word(0, 16'h0003);  // LDI R1,3
    put_word(2, 16'h0403);  // LDI R2,3
    put_word(4, 16'h4100);  // SUB R1,R2
    put_word(6, 16'hC020);  // BEQ 0x20
    put_word(32, 16'hF000); // HLT
    run_program(20);
    chk("beq_pc", dp_pc, 8'h22);
    chk("sub_r1_zero", dp_r[0], 8'h00);

    // ST/LD round trip and INC/DEC wrap
    fill_nops();
    put_word(0, 16'h04AA);  // LDI R2,0xAA
    put_word(2, 16'h2140);  // ST R2 -> [0x40]
    put_word(4, 16'h1840);  // LD R3 <- [0x40]
    put_word(6, 16'h0CFF);  // LDI R4,0xFF
    put_word(8, 16'h9C00);  // INC R4
    put_word(10, 16'h2341); // ST R4 -> [0x41]
    put_word(12, 16'hAC00); // DEC R4
    put_word(14, 16'hF000); // HLT
    run_program(20);
    chk("st_mem40", dp_mem[8'h40], 8'hAA);
    chk("ld_r3", dp_r[2], 8'hAA);
    chk("inc_wrap_mem41", dp_mem[8'h41], 8'h00);
    chk("dec_wrap_r4", dp_r[3], 8'hFF);

    // randomized programs (no explicit HLT; misaligned fetches may still hit one)
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 256; i++) prog_mem[i] = 8'($urandom_range(0, 255));
      for (int a = 0; a < 256; a += 2) begin
        w = {4'($urandom_range(0, 14)), 12'($urandom_range(0, 4095))};
        put_word(a, w);
      end
      run_program(40);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
